t_ff_pulse_sequencer: RTL and testbench
=======================================

// Module: t_ff_pulse_sequencer
// PURPOSE
//   Sequencer driving the t input of a downstream t_ff: on a start request it emits a
//   programmed number of one-cycle toggle pulses spaced a programmed number of cycles
//   apart, then reports completion. Sits between control logic and a t_ff or t_ff bank.
// PARAMETERS
//   CNT_W  8  width of pulse-count request and remaining counter
//   PER_W  8  width of pulse-period request, in clk cycles
// PORTS
//   clk        in   1      single clock, all state updates on posedge
//   rst        in   1      synchronous, active-low reset; sampled on posedge clk
//   start      in   1      request; accepted only in IDLE or DONE
//   pulses     in   CNT_W  number of t pulses N, sampled when start accepted
//   period     in   PER_W  spacing P in cycles, sampled when start accepted; 0 means 1
//   abort      in   1      cancel a running sequence
//   t          out  1      registered toggle pulse to t_ff
//   busy       out  1      high while in RUN
//   done       out  1      one-cycle completion strobe (normal finish only)
//   remaining  out  CNT_W  pulses still to issue
//   shadow_q   out  1      present only with T_FF_SEQ_SHADOW_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst==0 at posedge): state=IDLE; t=0, busy=0, done=0, remaining=0,
//     timer=0, shadow_q=0. Reset has priority over start/abort, including mid-RUN.
//   - All outputs registered. States: IDLE, RUN, DONE.
//   - IDLE/DONE, start=1 at edge k, pulses!=0: latch N, P=max(period,1);
//     at k: state=RUN, busy=1, remaining=N, timer=P.
//   - IDLE/DONE, start=1, pulses==0: state=DONE at k, done=1 for one cycle, busy stays 0,
//     no t pulse.
//   - DONE lasts exactly one cycle (done=1, busy=0), then IDLE unless start accepted.
//   - RUN: timer decrements each cycle; at the edge where timer would reach 0,
//     t=1 for that cycle, remaining-=1, timer reloads P. t pulses appear at edges
//     k+P, k+2P, ... k+N*P. With P=1, t stays high N consecutive cycles.
//   - After last pulse (remaining==0): at edge k+N*P+1 state=DONE, busy=0, done=1, t=0.
//   - start while RUN: ignored; latched N/P unchanged.
//   - abort=1 in RUN: next edge state=IDLE, busy=0, t=0, remaining=0, done=0; abort
//     wins over a pulse due at the same edge. abort in IDLE/DONE: no effect.
//   - start and abort both high in IDLE/DONE: start accepted, abort ignored.
//   - remaining never wraps; timer and remaining are unsigned, no overflow possible.
// CONFIGURATION
//   T_FF_SEQ_SHADOW_EN defined: shadow_q port present; register mirroring the driven
//     t_ff state: reset 0, inverts at each edge where t is registered high, holds
//     otherwise, unaffected by abort. Lets monitors check the t_ff without probing it.
//   T_FF_SEQ_SHADOW_EN undefined: shadow_q port and register absent; all else identical.
// TESTING
//   1. rst=0 for 2 cycles with start=1 -> t=0, busy=0, done=0, remaining=0 throughout.
//   2. start, N=3, P=4 at edge k -> t high at k+4,k+8,k+12 only; remaining 3,2,1,0;
//      done high only at k+13; busy high k..k+12.
//   3. start, N=2, period=0 -> treated P=1: t high at k+1,k+2; done at k+3.
//   4. start, N=0 -> done at k for one cycle; busy and t never high.
//   5. start N=5 P=4; start N=9 at k+2 (ignored); abort at k+6 -> single t at k+4,
//      IDLE at k+7, done never high, remaining=0.
//   6. rst=0 at k+5 mid-RUN -> all outputs 0 at next edge; with T_FF_SEQ_SHADOW_EN,
//      shadow_q toggles per t in test 2 (ends 1) and clears on reset.

Source files
------------

// File: rtl/t_ff_pulse_sequencer.sv
// Toggle-pulse sequencer for a downstream t_ff: N one-cycle t pulses spaced P cycles apart.
// Optional T_FF_SEQ_SHADOW_EN adds shadow_q, a register tracking the driven t_ff state.
module t_ff_pulse_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pulses,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
`ifdef T_FF_SEQ_SHADOW_EN
  ,
  output logic             shadow_q
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic             t_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] rem_q;
  logic [PER_W-1:0] timer_q;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] per_d;

  assign per_d = (period == '0) ? PER_W'(1) : period;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      timer_q <= '0;
      per_q   <= '0;
    end else begin
      t_q    <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            if (pulses == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              rem_q   <= '0;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              rem_q   <= pulses;
              per_q   <= per_d;
              timer_q <= per_d;
            end
          end
        end
        S_RUN: begin
          // abort outranks both the finish transition and a pulse due this edge
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rem_q   <= '0;
            timer_q <= '0;
          end else if (rem_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (timer_q == PER_W'(1)) begin
            t_q     <= 1'b1;
            rem_q   <= rem_q - CNT_W'(1);
            timer_q <= per_q;
          end else begin
            timer_q <= timer_q - PER_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign t         = t_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

`ifdef T_FF_SEQ_SHADOW_EN
  // flips on each edge where the t_ff samples t high, so it tracks the t_ff output
  always_ff @(posedge clk) begin
    if (!rst) shadow_q <= 1'b0;
    else if (t_q) shadow_q <= ~shadow_q;
  end
`endif

endmodule

// File: tb/tb_t_ff_pulse_sequencer.sv
// Self-checking bench for t_ff_pulse_sequencer against a formula-based timing model.
module tb_t_ff_pulse_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] pulses, period;
  logic       t, busy, done;
  logic [7:0] remaining;
`ifdef T_FF_SEQ_SHADOW_EN
  logic       shadow_q;
`endif

  int errors = 0;
  int checks = 0;

  t_ff_pulse_sequencer #(.CNT_W(8), .PER_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pulses(pulses), .period(period),
    .abort(abort), .t(t), .busy(busy), .done(done), .remaining(remaining)
`ifdef T_FF_SEQ_SHADOW_EN
    , .shadow_q(shadow_q)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a sequence started at cycle k with N,P pulses at k+j*P (j=1..N),
  // has remaining = N - floor((c-k)/P), and finishes with done at k+N*P+1.
  int         cyc = 0;
  bit         m_active = 0;
  int         m_k, m_n, m_p;
  logic       exp_t = 0, exp_busy = 0, exp_done = 0, exp_sh = 0;
  logic [7:0] exp_rem = '0;

  task automatic tick();
    logic prev_t;
    int   d;
    @(posedge clk);
    cyc++;
    prev_t = exp_t;
    if (!rst) begin
      m_active = 0;
      exp_t = 0; exp_busy = 0; exp_done = 0; exp_rem = '0; exp_sh = 0;
    end else begin
      exp_sh   = exp_sh ^ prev_t;
      exp_t    = 0;
      exp_done = 0;
      if (m_active) begin
        d = cyc - m_k;
        if (abort) begin
          m_active = 0; exp_busy = 0; exp_rem = '0;
        end else if (d == m_n * m_p + 1) begin
          m_active = 0; exp_busy = 0; exp_done = 1; exp_rem = '0;
        end else begin
          exp_busy = 1;
          exp_t    = (d % m_p == 0);
          exp_rem  = 8'(m_n - d / m_p);
        end
      end else begin
        exp_busy = 0;
        exp_rem  = '0;
        if (start) begin
          if (pulses == 0) begin
            exp_done = 1;
          end else begin
            m_active = 1; m_k = cyc; m_n = int'(pulses);
            m_p = (period == 0) ? 1 : int'(period);
            exp_busy = 1; exp_rem = pulses;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0; start = 1; pulses = 8'd5; period = 8'd2; abort = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({t, busy, done, remaining} !== 11'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got t/busy/done/rem=%b/%b/%b/%0d need 0/0/0/0", cyc, t, busy, done, remaining);
      end
      checks++;
    end
    rst = 1; start = 0;
    tick();
  endtask

  task automatic test_basic();
    int npulse = 0;
    int ndone  = 0;
    start = 1; pulses = 8'd3; period = 8'd4;
    for (int i = 0; i <= 16; i++) begin
      tick();
      start = 0;
      npulse += int'(t);
      ndone  += int'(done);
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL basic k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
    end
    if (npulse != 3 || ndone != 1) begin
      errors++;
      $display("FAIL basic_counts got pulses=%0d dones=%0d need 3/1", npulse, ndone);
    end
    checks++;
`ifdef T_FF_SEQ_SHADOW_EN
    if (shadow_q !== 1'b1) begin
      errors++;
      $display("FAIL shadow_after_basic got %b need 1", shadow_q);
    end
    checks++;
`endif
  endtask

  task automatic test_period_zero();
    start = 1; pulses = 8'd2; period = 8'd0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      start = 0;
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL period_zero k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
    end
  endtask

  task automatic test_zero_pulses();
    start = 1; pulses = 8'd0; period = 8'd3;
    for (int i = 0; i <= 3; i++) begin
      tick();
      start = 0;
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL zero_pulses k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
    end
  endtask

  task automatic test_ignore_and_abort();
    start = 1; pulses = 8'd5; period = 8'd4;
    for (int i = 0; i <= 10; i++) begin
      tick();
      start  = (i == 1);
      pulses = (i == 1) ? 8'd9 : 8'd5;
      abort  = (i == 6);
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL start_ignore_abort k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
    end
    abort = 0;
  endtask

  task automatic test_reset_midrun();
    start = 1; pulses = 8'd3; period = 8'd2;
    for (int i = 0; i <= 8; i++) begin
      tick();
      start = 0;
      rst   = (i != 4);
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL reset_midrun k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
      if (i == 5 && {t, busy, done, remaining} !== 11'd0) begin
        errors++;
        $display("FAIL reset_midrun_clear got t/busy/done/rem=%b/%b/%b/%0d need 0/0/0/0", t, busy, done, remaining);
      end
      if (i == 5) checks++;
`ifdef T_FF_SEQ_SHADOW_EN
      if (i == 5 && shadow_q !== 1'b0) begin
        errors++;
        $display("FAIL shadow_reset got %b need 0", shadow_q);
      end
      if (i == 5) checks++;
`endif
    end
    rst = 1;
  endtask

  task automatic test_back_to_back();
    start = 1; pulses = 8'd1; period = 8'd1; abort = 1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      abort = 0;
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL back_to_back k+%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 i, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
    end
    start = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start  = ($urandom_range(3) == 0);
      pulses = 8'($urandom_range(4));
      period = 8'($urandom_range(3));
      abort  = ($urandom_range(15) == 0);
      rst    = ($urandom_range(63) != 0);
      tick();
      if ({t, busy, done, remaining} !== {exp_t, exp_busy, exp_done, exp_rem}) begin
        errors++;
        $display("FAIL random cyc=%0d got t/busy/done/rem=%b/%b/%b/%0d need %b/%b/%b/%0d",
                 cyc, t, busy, done, remaining, exp_t, exp_busy, exp_done, exp_rem);
      end
      checks++;
`ifdef T_FF_SEQ_SHADOW_EN
      if (shadow_q !== exp_sh) begin
        errors++;
        $display("FAIL random_shadow cyc=%0d got %b need %b", cyc, shadow_q, exp_sh);
      end
      checks++;
`endif
    end
    start = 0; abort = 0; rst = 1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_period_zero();
    test_zero_pulses();
    test_ignore_and_abort();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
